argmax_seq_ctrl: RTL and testbench

ARGMAX_SEQ_CTRL -- requirements
Module: argmax_seq_ctrl

---
 rtl/argmax_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_argmax_seq_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/argmax_seq_ctrl.sv
// Sequential argmax over one frame of NUM_CLASSES signed scores.
// Scores stream in class order. The block reports the largest score and its index,
// and a tie keeps the lowest index.
module argmax_seq_ctrl #(
   parameter int unsigned NUM_CLASSES = 10,
   parameter int unsigned DATA_W      = 62,
   parameter int unsigned IDX_W       = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              score_valid,
   input  logic [DATA_W-1:0] score_data,
   output logic              score_ready,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_max,
   output logic [IDX_W-1:0]  res_index,
   output logic              busy,
   output logic [15:0]       frame_cnt
);

   localparam int unsigned LAST_IDX = NUM_CLASSES - 1;
   localparam int unsigned CNT_W    = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] max_q, max_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              score_ready_q, score_ready_d;
   logic              res_valid_q, res_valid_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic              hs_c;

   // Next-state, datapath update and registered output decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      max_d       = max_q;
      idx_d       = idx_q;
      frame_cnt_d = frame_cnt_q;
      hs_c        = (state_q == S_ACCUM) && score_valid;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ACCUM;
               cnt_d   = '0;
            end
         end
         S_ACCUM: begin
            if (hs_c) begin
               // The first score seeds the maximum. Later scores replace it only if strictly greater.
               if (cnt_q == '0) begin
                  max_d = score_data;
                  idx_d = '0;
               end else if ($signed(score_data) > $signed(max_q)) begin
                  max_d = score_data;
                  idx_d = cnt_q;
               end
               cnt_d = cnt_q + IDX_W'(1);
               if (cnt_q == IDX_W'(LAST_IDX)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (res_ready) begin
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
               if (start) begin
                  state_d = S_ACCUM;
                  cnt_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      score_ready_d = (state_d == S_ACCUM);
      res_valid_d   = (state_d == S_DONE);
      busy_d        = (state_d != S_IDLE);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         max_q         <= '0;
         idx_q         <= '0;
         score_ready_q <= 1'b0;
         res_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         max_q         <= max_d;
         idx_q         <= idx_d;
         score_ready_q <= score_ready_d;
         res_valid_q   <= res_valid_d;
         busy_q        <= busy_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign score_ready = score_ready_q;
   assign res_valid   = res_valid_q;
   assign res_max     = max_q;
   assign res_index   = idx_q;
   assign busy        = busy_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_argmax_seq_ctrl.sv
// Directed testbench for argmax_seq_ctrl using the default parameters.
module tb_argmax_seq_ctrl;

   localparam int unsigned DW = 62;
   localparam int unsigned IW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          score_valid;
   logic [DW-1:0] score_data;
   logic          score_ready;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_max;
   logic [IW-1:0] res_index;
   logic          busy;
   logic [15:0]   frame_cnt;

   int checks   = 0;
   int failures = 0;

   argmax_seq_ctrl #(.NUM_CLASSES(10), .DATA_W(DW), .IDX_W(IW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .score_valid (score_valid),
      .score_data  (score_data),
      .score_ready (score_ready),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_max     (res_max),
      .res_index   (res_index),
      .busy        (busy),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] sc(input int v);
      return DW'(v);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_result(input string tag, input logic [DW-1:0] emax, input logic [IW-1:0] eidx);
      check({tag, "_valid"}, 64'(res_valid), 64'(1));
      check({tag, "_max"},   64'(res_max),   64'(emax));
      check({tag, "_index"}, 64'(res_index), 64'(eidx));
      check({tag, "_ready"}, 64'(score_ready), 64'(0));
      check({tag, "_busy"},  64'(busy),      64'(1));
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy",  64'(busy),        64'(1));
      check("start_ready", 64'(score_ready), 64'(1));
   endtask

   // Sends ten scores, optionally with idle gaps and with start held high during ACCUM.
   // Returns at the negedge right after the final handshake.
   task automatic send_frame(input logic [DW-1:0] s [10], input bit gaps, input bit poke_start);
      for (int i = 0; i < 10; i++) begin
         if (gaps) begin
            int n;
            n = int'($urandom_range(0, 2));
            for (int g = 0; g < n; g++) begin
               @(negedge clk);
               score_valid = 1'b0;
               score_data  = '1;
               start       = poke_start;
            end
         end
         @(negedge clk);
         check("accum_ready", 64'(score_ready), 64'(1));
         score_valid = 1'b1;
         score_data  = s[i];
         start       = poke_start;
      end
      @(negedge clk);
      score_valid = 1'b0;
      start       = 1'b0;
   endtask

   task automatic check_idle(input string tag, input logic [15:0] efc);
      check({tag, "_valid"}, 64'(res_valid),   64'(0));
      check({tag, "_busy"},  64'(busy),        64'(0));
      check({tag, "_ready"}, 64'(score_ready), 64'(0));
      check({tag, "_fc"},    64'(frame_cnt),   64'(efc));
   endtask

   logic [DW-1:0] f [10];

   initial begin
      rst_n       = 1'b0;
      start       = 1'b1;
      score_valid = 1'b1;
      score_data  = sc(77);
      res_ready   = 1'b0;
      repeat (3) @(negedge clk);
      // Reset state. Reset also wins over start and valid being held high.
      check_idle("rst", 16'd0);
      check("rst_max", 64'(res_max),   64'(0));
      check("rst_idx", 64'(res_index), 64'(0));
      rst_n       = 1'b1;
      start       = 1'b0;
      score_valid = 1'b0;
      @(negedge clk);
      check_idle("post_rst", 16'd0);

      // Frame 1: mixed scores. The first maximum, 9, is at index 3.
      res_ready = 1'b1;
      f = '{sc(3), sc(7), sc(-2), sc(9), sc(9), sc(1), sc(0), sc(-5), sc(4), sc(8)};
      pulse_start();
      send_frame(f, 1'b0, 1'b0);
      check_result("f1", sc(9), 4'd3);
      @(negedge clk);
      check_idle("f1_done", 16'd1);

      // Frame 2: all scores are -1. A tie keeps index 0, and the compare is signed.
      for (int i = 0; i < 10; i++) f[i] = sc(-1);
      pulse_start();
      send_frame(f, 1'b0, 1'b0);
      check_result("f2", sc(-1), 4'd0);
      @(negedge clk);
      check_idle("f2_done", 16'd2);

      // Frame 3: extreme values, with the maximum at the last class.
      for (int i = 0; i < 9; i++) f[i] = {1'b1, {(DW-1){1'b0}}};
      f[9] = {1'b0, {(DW-1){1'b1}}};
      pulse_start();
      send_frame(f, 1'b0, 1'b0);
      check_result("f3", {1'b0, {(DW-1){1'b1}}}, 4'd9);
      @(negedge clk);
      check_idle("f3_done", 16'd3);

      // Frame 4: gaps in valid and start held during ACCUM. DONE then stalls for 5 cycles with start high.
      res_ready = 1'b0;
      f = '{sc(5), sc(-3), sc(12), sc(12), sc(0), sc(11), sc(-20), sc(12), sc(7), sc(2)};
      pulse_start();
      send_frame(f, 1'b1, 1'b1);
      check_result("f4", sc(12), 4'd2);
      score_valid = 1'b1;
      score_data  = sc(1000);
      for (int c = 0; c < 5; c++) begin
         start = 1'b1;
         @(negedge clk);
         check_result("f4_hold", sc(12), 4'd2);
         check("f4_hold_fc", 64'(frame_cnt), 64'(3));
      end
      score_valid = 1'b0;
      // Result consumed with start in the same cycle, so the block goes straight back to ACCUM.
      res_ready = 1'b1;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      res_ready = 1'b0;
      check("b2b_valid", 64'(res_valid),   64'(0));
      check("b2b_ready", 64'(score_ready), 64'(1));
      check("b2b_busy",  64'(busy),        64'(1));
      check("b2b_fc",    64'(frame_cnt),   64'(4));

      // Frame 5: the back-to-back frame.
      f = '{sc(-7), sc(-8), sc(4), sc(-1), sc(6), sc(6), sc(3), sc(-9), sc(5), sc(0)};
      send_frame(f, 1'b0, 1'b0);
      check_result("f5", sc(6), 4'd4);
      res_ready = 1'b1;
      @(negedge clk);
      check_idle("f5_done", 16'd5);

      // Frame 6: reset after four handshakes discards the partial frame.
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         score_valid = 1'b1;
         score_data  = sc(100 + i);
      end
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b1;
      @(negedge clk);
      rst_n       = 1'b1;
      start       = 1'b0;
      score_valid = 1'b0;
      check_idle("mid_rst", 16'd0);
      check("mid_rst_max", 64'(res_max),   64'(0));
      check("mid_rst_idx", 64'(res_index), 64'(0));
      repeat (3) begin
         @(negedge clk);
         check_idle("mid_rst_quiet", 16'd0);
      end

      // Frame 7: a clean frame after reset.
      f = '{sc(2), sc(-4), sc(1), sc(0), sc(-1), sc(2), sc(3), sc(3), sc(-6), sc(1)};
      pulse_start();
      send_frame(f, 1'b0, 1'b0);
      check_result("f7", sc(3), 4'd6);
      @(negedge clk);
      check_idle("f7_done", 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
